fb_reader: RTL and testbench

- Read-side counterpart of the framebuffer pixel writer.
- Sequentially scans the framebuffer SRAM in raster order and reads 16-bit RGB555 pixels over the shared dq bus.
- Buffers the pixels in a small FIFO and presents them to the display path with a valid/ready handshake, tagged with their x/y coordinates.
- Arbitrates the SRAM bus with the writer: on request it stops fetching, drains in-flight reads, then grants the bus.

---
 rtl/fb_reader.sv | 162 ++++++++++++++++
 tb/tb_fb_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_reader.sv
// Raster-order framebuffer reader: fetches RGB555 pixels from SRAM, buffers them in a
// first-word-fall-through FIFO, and yields the bus to the pixel writer on request.
module fb_reader #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dq,
    output logic [16:0] addr,
    output logic        oe_n,
    input  logic        wr_req,
    output logic        wr_gnt,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [8:0]       X_LAST  = 9'(H_RES - 1);
    localparam logic [8:0]       Y_LAST  = 9'(V_RES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {FETCH, DRAIN, GRANT} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        sof;
    } pix_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [8:0]       r_fx;
    logic [8:0]       r_fy;
    logic [16:0]      r_addr;
    logic             r_oe_n;
    logic             r_wr_gnt;
    logic [CNT_W-1:0] r_infl;
    logic [CNT_W-1:0] w_infl_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    logic             r_vld_p [RD_LAT];
    logic [8:0]       r_x_p   [RD_LAT];
    logic [8:0]       r_y_p   [RD_LAT];
    logic             r_sof_p [RD_LAT];

    pix_t             r_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    pix_t             w_head;

    // A read is only launched when a FIFO slot is already reserved for its data.
    assign w_issue    = (r_state == FETCH) && !wr_req && ((r_count + r_infl) < DEPTH_C);
    assign w_push     = r_vld_p[RD_LAT-1];
    assign w_pop      = pix_valid && pix_ready;
    assign w_infl_nxt = r_infl + CNT_W'(w_issue) - CNT_W'(w_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FETCH:   if (wr_req)          w_state_nxt = DRAIN;
            DRAIN:   if (r_infl == '0)    w_state_nxt = GRANT;
            GRANT:   if (!wr_req)         w_state_nxt = FETCH;
            default:                      w_state_nxt = FETCH;
        endcase
    end

    // Issue stage: scan counters, SRAM address/enable, grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fx     <= '0;
            r_fy     <= '0;
            r_addr   <= '0;
            r_oe_n   <= 1'b1;
            r_wr_gnt <= 1'b0;
            r_infl   <= '0;
        end else begin
            r_infl   <= w_infl_nxt;
            r_oe_n   <= (w_infl_nxt == '0);
            r_wr_gnt <= (w_state_nxt == GRANT);
            if (w_issue) begin
                r_addr <= {r_fy[7:0], r_fx};
                if (r_fx == X_LAST) begin
                    r_fx <= '0;
                    r_fy <= (r_fy == Y_LAST) ? '0 : r_fy + 9'd1;
                end else begin
                    r_fx <= r_fx + 9'd1;
                end
            end
        end
    end

    // Latency stage: coordinates ride alongside the outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_vld_p[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_x_p[0]   <= r_fx;
        r_y_p[0]   <= r_fy;
        r_sof_p[0] <= (r_fx == '0) && (r_fy == '0);
        for (int i = 1; i < RD_LAT; i++) begin
            r_x_p[i]   <= r_x_p[i-1];
            r_y_p[i]   <= r_y_p[i-1];
            r_sof_p[i] <= r_sof_p[i-1];
        end
    end

    // Capture stage: pixel FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {dq, r_x_p[RD_LAT-1], r_y_p[RD_LAT-1], r_sof_p[RD_LAT-1]};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign pix_valid = (r_count != '0);
    assign pix_data  = pix_valid ? w_head.data : '0;
    assign pix_x     = pix_valid ? w_head.x    : '0;
    assign pix_y     = pix_valid ? w_head.y    : '0;
    assign pix_sof   = pix_valid && w_head.sof;

    assign addr   = r_addr;
    assign oe_n   = r_oe_n;
    assign wr_gnt = r_wr_gnt;

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: SRAM model returns the low 16 address bits; pixels are
// scoreboarded against an independent raster-order model.
module tb_fb_reader;
    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] dq;
    logic [16:0] addr;
    logic        oe_n;
    logic        wr_req;
    logic        wr_gnt;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;

    logic [15:0] r_dq;
    logic        ready_en;
    logic        ovf;
    logic [8:0]  m_x;
    logic [8:0]  m_y;
    int          n_checks;
    int          n_fail;
    int          n_iss_total;
    logic [63:0] exp_q [$];

    fb_reader #(
        .H_RES(H_RES), .V_RES(V_RES), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .dq(dq), .addr(addr), .oe_n(oe_n),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .pix_data(pix_data), .pix_x(pix_x),
        .pix_y(pix_y), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM: data for the address driven in one cycle appears on dq the next.
    always @(posedge clk) r_dq <= (oe_n === 1'b0) ? addr[15:0] : 16'hDEAD;
    assign dq = r_dq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({29'd0, m_y[6:0], m_x, m_x, m_y, (m_x == 9'd0 && m_y == 9'd0)});
            if (m_x == 9'(H_RES - 1)) begin
                m_x = 9'd0;
                m_y = (m_y == 9'(V_RES - 1)) ? 9'd0 : m_y + 9'd1;
            end else begin
                m_x = m_x + 9'd1;
            end
        end
    endtask

    task automatic do_reset(input int n_exp, input logic rdy, input logic wreq);
        @(negedge clk);
        ready_en = 1'b0;
        rst      = 1'b1;
        wr_req   = wreq;
        @(negedge clk);
        check("rst_addr",   64'(addr), 64'd0);
        check("rst_oe_n",   64'(oe_n), 64'd1);
        check("rst_wr_gnt", 64'(wr_gnt), 64'd0);
        check("rst_valid",  64'(pix_valid), 64'd0);
        check("rst_fields", {29'd0, pix_data, pix_x, pix_y, pix_sof}, 64'd0);
        @(negedge clk);
        exp_q.delete();
        m_x = 9'd0;
        m_y = 9'd0;
        push_expect(n_exp);
        ready_en = rdy;
        rst      = 1'b0;
    endtask

    task automatic wait_pixels(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int   base;
        int   gaps;
        int   n;
        logic found;
        logic bad;
        logic first;

        rst = 1'b1; wr_req = 1'b0; ready_en = 1'b0; pix_ready = 1'b0; ovf = 1'b0;
        n_checks = 0; n_fail = 0; n_iss_total = 0; m_x = 9'd0; m_y = 9'd0;

        fork
            forever begin
                @(posedge clk);
                #1;
                pix_ready = ready_en && (exp_q.size() != 0);
            end
            begin
                logic [16:0] prev_addr = '0;
                logic        prev_oe   = 1'b1;
                forever begin
                    @(negedge clk);
                    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
                        check("pix_queued", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0)
                            check("pix", {29'd0, pix_data, pix_x, pix_y, pix_sof}, exp_q.pop_front());
                    end
                    if (oe_n === 1'b0 && (prev_oe || addr !== prev_addr)) n_iss_total++;
                    prev_oe   = (oe_n !== 1'b0);
                    prev_addr = addr;
                    if (rst === 1'b0 && dut.w_push === 1'b1 && dut.w_pop !== 1'b1 &&
                        int'(dut.r_count) == FIFO_DEPTH) ovf = 1'b1;
                end
            end
        join_none

        // Latency to first pixel and a run past the first line wrap.
        do_reset(330, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("lat_early", 64'(pix_valid), 64'd0);
        @(negedge clk);
        check("lat_first", 64'(pix_valid), 64'd1);
        wait_pixels("line_wrap", 1000);

        // Back-pressure: exactly FIFO_DEPTH reads, then nothing until drained.
        do_reset(0, 1'b0, 1'b0);
        base = n_iss_total;
        repeat (20) @(negedge clk);
        check("bp_issues", 64'(n_iss_total - base), 64'd4);
        check("bp_addr",   64'(addr), 64'd3);
        check("bp_oe_n",   64'(oe_n), 64'd1);
        check("bp_valid",  64'(pix_valid), 64'd1);
        push_expect(8);
        ready_en = 1'b1;
        wait_pixels("bp_drain", 100);

        // Bus request after pixel (10,0) issued, then release.
        do_reset(11, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (addr == 17'd10 && oe_n == 1'b0) found = 1'b1;
        end
        check("arb_seen10", 64'(found), 64'd1);
        wr_req = 1'b1;
        repeat (3) @(negedge clk);
        check("arb_gnt_lat", 64'(wr_gnt), 64'd1);
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (oe_n !== 1'b1 || addr !== 17'd10 || wr_gnt !== 1'b1) bad = 1'b1;
        end
        check("arb_hold", 64'(bad), 64'd0);
        wr_req = 1'b0;
        @(negedge clk);
        check("arb_gnt_drop", 64'(wr_gnt), 64'd0);
        push_expect(20);
        wait_pixels("arb_resume", 200);

        // Full frame plus wrap, no bubbles.
        do_reset(H_RES * V_RES + 4, 1'b1, 1'b0);
        first = 1'b0;
        gaps  = 0;
        n     = 0;
        while (exp_q.size() != 0 && n < 80000) begin
            @(negedge clk);
            n++;
            if (pix_valid) first = 1'b1;
            else if (first) gaps++;
        end
        check("frame_drain", 64'(exp_q.size()), 64'd0);
        check("frame_gaps",  64'(gaps), 64'd0);

        // Reset while FIFO full and bus granted.
        do_reset(0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("full_valid", 64'(pix_valid), 64'd1);
        wr_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (wr_gnt == 1'b1) found = 1'b1;
        end
        check("full_gnt", 64'(found), 64'd1);
        do_reset(5, 1'b1, 1'b0);
        wait_pixels("post_rst", 100);

        // Reset and bus request together.
        do_reset(6, 1'b0, 1'b1);
        base = n_iss_total;
        @(negedge clk);
        check("seq_gnt_c0", 64'(wr_gnt), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (wr_gnt == 1'b1) found = 1'b1;
        end
        check("seq_gnt", 64'(found), 64'd1);
        check("seq_no_issue", 64'(n_iss_total - base), 64'd0);
        check("seq_oe_n", 64'(oe_n), 64'd1);
        wr_req   = 1'b0;
        ready_en = 1'b1;
        wait_pixels("seq_resume", 100);

        check("no_overflow", 64'(ovf), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
